// File: rtl/qam_demodulator_pkg.sv
// ---------------------------------------------------------------------------
// qam_demodulator_pkg
// Shared types, widths and slicing helpers for the 16-QAM demodulator.
//   DEMOD_STATE  : symbol-tracking FSM states (IDLE, INTEGRATE)
//   QAM_BLOCK_W  : width of one demodulated 16-QAM symbol
//   absSat       : |x| of a signed 32-bit value, -2^31 clamps to 2^31-1
//   sliceAxis    : {negative, magnitude above threshold} for one axis
// ---------------------------------------------------------------------------
package qam_demodulator_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    INTEGRATE = 1'b1
  } DEMOD_STATE;

  localparam int QAM_BLOCK_W = 4;
  localparam int SAMPLE_W    = 20;
  localparam int REF_W       = 18;
  localparam int PROD_W      = SAMPLE_W + REF_W;
  localparam int OUT_W       = 32;

  localparam logic [OUT_W-1:0] OUT_MAX = 32'h7FFF_FFFF;
  localparam logic [OUT_W-1:0] OUT_MIN = 32'h8000_0000;

  // Magnitude of a signed 32-bit value; the one value without a positive
  // counterpart is clamped rather than wrapped back to itself.
  function automatic logic [OUT_W-1:0] absSat(input logic [OUT_W-1:0] value);
    logic [OUT_W-1:0] mag;
    if (value == OUT_MIN) begin
      mag = OUT_MAX;
    end else if (value[OUT_W-1]) begin
      mag = ~value + 32'd1;
    end else begin
      mag = value;
    end
    return mag;
  endfunction

  // {sign bit, outer-level bit} for one constellation axis.
  function automatic logic [1:0] sliceAxis(input logic [OUT_W-1:0] value,
                                           input logic [OUT_W-1:0] threshold);
    return {value[OUT_W-1], (absSat(value) > threshold)};
  endfunction

endpackage

// File: rtl/qam_demodulator_integrator.sv
// ---------------------------------------------------------------------------
// qam_demodulator_integrator
// One mixing/integrate-and-dump arm (used once for I, once for Q).
//   Stage 1 : registers ipSample * ipRef (38-bit signed), every cycle.
//   Stage 2 : adds the registered product into the ACC_W accumulator when
//             ipAcc is high; with ipFinal it captures acc+product into the
//             dump register and restarts from zero. ipClear zeroes the
//             accumulator (symbol start / resync) and wins over ipAcc.
//   Stage 3 : combinational arithmetic shift by SHIFT and saturation of
//             the dump register to signed 32 bits; the top registers it.
// Ports
//   ipClk, ipReset      : clock, synchronous active-high reset
//   ipSample  [19:0]    : signed modulated sample
//   ipRef     [17:0]    : signed NCO reference for this arm
//   ipAcc               : stage-1 product is valid and belongs to the symbol
//   ipFinal             : that product is the last one of the symbol
//   ipClear             : discard the running accumulation
//   opSat     [31:0]    : shifted, saturated dump value
//   opSatHit            : opSat was clamped
// ---------------------------------------------------------------------------
module qam_demodulator_integrator
  import qam_demodulator_pkg::*;
#(
  parameter int SHIFT = 12,
  parameter int ACC_W = 44
) (
  input  logic                ipClk,
  input  logic                ipReset,
  input  logic [SAMPLE_W-1:0] ipSample,
  input  logic [REF_W-1:0]    ipRef,
  input  logic                ipAcc,
  input  logic                ipFinal,
  input  logic                ipClear,
  output logic [OUT_W-1:0]    opSat,
  output logic                opSatHit
);

  logic signed [PROD_W-1:0] sampleExt;
  logic signed [PROD_W-1:0] refExt;
  logic signed [PROD_W-1:0] prodReg;
  logic signed [ACC_W-1:0]  accReg;
  logic signed [ACC_W-1:0]  accSum;
  logic signed [ACC_W-1:0]  dumpReg;
  logic signed [ACC_W-1:0]  shifted;
  logic                     fits;

  // Both operands are widened to the full product width first so the
  // multiply is exact without relying on context-width rules.
  assign sampleExt = {{(PROD_W-SAMPLE_W){ipSample[SAMPLE_W-1]}}, ipSample};
  assign refExt    = {{(PROD_W-REF_W){ipRef[REF_W-1]}}, ipRef};
  assign accSum    = accReg + {{(ACC_W-PROD_W){prodReg[PROD_W-1]}}, prodReg};

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      prodReg <= '0;
      accReg  <= '0;
      dumpReg <= '0;
    end else begin
      prodReg <= sampleExt * refExt;
      if (ipClear) begin
        accReg <= '0;
      end else if (ipAcc) begin
        if (ipFinal) begin
          // Dump includes the final product; restarting at zero (not at
          // the product) keeps the next symbol's first sample intact.
          dumpReg <= accSum;
          accReg  <= '0;
        end else begin
          accReg <= accSum;
        end
      end
    end
  end

  // The shifted value fits in 32 bits only when every bit from 31 upward
  // is a copy of the sign.
  always_comb begin
    shifted  = dumpReg >>> SHIFT;
    fits     = (&shifted[ACC_W-1:OUT_W-1]) || !(|shifted[ACC_W-1:OUT_W-1]);
    opSat    = shifted[OUT_W-1:0];
    opSatHit = 1'b0;
    if (!fits) begin
      opSatHit = 1'b1;
      opSat    = shifted[ACC_W-1] ? OUT_MIN : OUT_MAX;
    end
  end

endmodule

// File: rtl/qam_demodulator.sv
// ---------------------------------------------------------------------------
// qam_demodulator
// Coherent 16-QAM demodulator: mixes the modulated stream with the NCO
// I/Q references, integrates SYMBOL_LEN valid products per symbol, dumps,
// scales, saturates and slices each symbol into a 4-bit block.
// Pipeline: stage 1 product, stage 2 accumulate/dump, stage 3 slice, so
// opQAMBlockValid follows a symbol's last sample by exactly 3 cycles.
// An ipSymbolStart in a cycle makes that cycle's sample the first of a new
// symbol; a partially integrated symbol is then discarded and counted.
// Ports
//   ipClk, ipReset        : clock, synchronous active-high reset
//   ipModulated [19:0]    : signed sample, qualified by ipModulatedValid
//   ipI, ipQ    [17:0]    : signed NCO references, aligned with the sample
//   ipSymbolStart         : one-cycle symbol alignment strobe
//   ipThreshold [31:0]    : unsigned outer-level magnitude threshold
//   opQAMBlock  [3:0]     : {I neg, |I|>thr, Q neg, |Q|>thr}
//   opQAMBlockValid       : one-cycle qualifier for opQAMBlock
//   opOverflow            : sticky, set by any saturation
//   opResyncCount [15:0]  : partial symbols discarded (wrapping)
// Build option QAM_DEMOD_ACC_OUT_EN adds opAccI/opAccQ [31:0]: the last
// saturated dump values, updated together with opQAMBlockValid.
// ---------------------------------------------------------------------------
module qam_demodulator
  import qam_demodulator_pkg::*;
#(
  parameter int SYMBOL_LEN = 64,
  parameter int SHIFT      = 12,
  parameter int ACC_W      = 44
) (
  input  logic                   ipClk,
  input  logic                   ipReset,
  input  logic [SAMPLE_W-1:0]    ipModulated,
  input  logic                   ipModulatedValid,
  input  logic [REF_W-1:0]       ipI,
  input  logic [REF_W-1:0]       ipQ,
  input  logic                   ipSymbolStart,
  input  logic [OUT_W-1:0]       ipThreshold,
  output logic [QAM_BLOCK_W-1:0] opQAMBlock,
  output logic                   opQAMBlockValid,
  output logic                   opOverflow,
  output logic [15:0]            opResyncCount
`ifdef QAM_DEMOD_ACC_OUT_EN
  ,
  output logic [OUT_W-1:0]       opAccI,
  output logic [OUT_W-1:0]       opAccQ
`endif
);

  localparam logic [15:0] LAST_COUNT = 16'(SYMBOL_LEN - 1);

  DEMOD_STATE       stateReg;
  logic             s1ValidReg;
  logic [15:0]      countReg;
  logic             dumpValidReg;

  logic             startIdle;
  logic             finalHit;
  logic             partial;
  logic             resync;
  logic             clearAcc;
  logic             accEn;

  logic [OUT_W-1:0] satI;
  logic [OUT_W-1:0] satQ;
  logic             satHitI;
  logic             satHitQ;
  logic [1:0]       sliceI;
  logic [1:0]       sliceQ;
  logic             absClamp;

  // Symbol bookkeeping, all evaluated against the product in stage 1.
  // The in-flight product counts as part of the partial symbol, so a strobe
  // right after a completed symbol (nothing pending) changes nothing.
  assign startIdle = ipSymbolStart && (stateReg == IDLE);
  assign finalHit  = s1ValidReg && (countReg == LAST_COUNT);
  assign partial   = (countReg != 16'd0) || s1ValidReg;
  assign resync    = ipSymbolStart && (stateReg == INTEGRATE) && partial && !finalHit;
  assign clearAcc  = startIdle || resync;
  assign accEn     = s1ValidReg && !resync;

  qam_demodulator_integrator #(
    .SHIFT (SHIFT),
    .ACC_W (ACC_W)
  ) integratorI (
    .ipClk    (ipClk),
    .ipReset  (ipReset),
    .ipSample (ipModulated),
    .ipRef    (ipI),
    .ipAcc    (accEn),
    .ipFinal  (finalHit),
    .ipClear  (clearAcc),
    .opSat    (satI),
    .opSatHit (satHitI)
  );

  qam_demodulator_integrator #(
    .SHIFT (SHIFT),
    .ACC_W (ACC_W)
  ) integratorQ (
    .ipClk    (ipClk),
    .ipReset  (ipReset),
    .ipSample (ipModulated),
    .ipRef    (ipQ),
    .ipAcc    (accEn),
    .ipFinal  (finalHit),
    .ipClear  (clearAcc),
    .opSat    (satQ),
    .opSatHit (satHitQ)
  );

  assign sliceI   = sliceAxis(satI, ipThreshold);
  assign sliceQ   = sliceAxis(satQ, ipThreshold);
  assign absClamp = (satI == OUT_MIN) || (satQ == OUT_MIN);

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      stateReg        <= IDLE;
      s1ValidReg      <= 1'b0;
      countReg        <= '0;
      dumpValidReg    <= 1'b0;
      opQAMBlock      <= '0;
      opQAMBlockValid <= 1'b0;
      opOverflow      <= 1'b0;
      opResyncCount   <= '0;
    end else begin
      if (startIdle) begin
        stateReg <= INTEGRATE;
      end

      // The strobe cycle's own sample already belongs to the new symbol.
      s1ValidReg <= ipModulatedValid && ((stateReg == INTEGRATE) || ipSymbolStart);

      if (clearAcc) begin
        countReg <= '0;
      end else if (accEn) begin
        countReg <= finalHit ? 16'd0 : countReg + 16'd1;
      end

      if (resync) begin
        opResyncCount <= opResyncCount + 16'd1;
      end

      dumpValidReg    <= accEn && finalHit;
      opQAMBlockValid <= dumpValidReg;
      if (dumpValidReg) begin
        opQAMBlock <= {sliceI, sliceQ};
        if (satHitI || satHitQ || absClamp) begin
          opOverflow <= 1'b1;
        end
      end
    end
  end

`ifdef QAM_DEMOD_ACC_OUT_EN
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      opAccI <= '0;
      opAccQ <= '0;
    end else if (dumpValidReg) begin
      opAccI <= satI;
      opAccQ <= satQ;
    end
  end
`endif

endmodule

// File: tb/tb_qam_demodulator.sv
// ---------------------------------------------------------------------------
// tb_qam_demodulator
// Two instances share all inputs: dut0 with default parameters, dut1 with
// SHIFT=0 to reach saturation. A behavioural model works per input cycle:
// it keeps the running I/Q sums of the current symbol with plain integer
// arithmetic and queues each completed symbol, due 3 cycles later.
// ---------------------------------------------------------------------------
module tb_qam_demodulator;

  localparam int SYMBOL_LEN = 64;

  logic        ipClk = 1'b0;
  logic        ipReset;
  logic [19:0] ipModulated;
  logic        ipModulatedValid;
  logic [17:0] ipI;
  logic [17:0] ipQ;
  logic        ipSymbolStart;
  logic [31:0] ipThreshold;

  logic [3:0]  blk [2];
  logic        bv  [2];
  logic        ovf [2];
  logic [15:0] rsc [2];
`ifdef QAM_DEMOD_ACC_OUT_EN
  logic [31:0] accOutI [2];
  logic [31:0] accOutQ [2];
`endif

  always #5 ipClk = ~ipClk;

  qam_demodulator #(.SYMBOL_LEN(SYMBOL_LEN), .SHIFT(12), .ACC_W(44)) dut0 (
    .ipClk(ipClk), .ipReset(ipReset), .ipModulated(ipModulated),
    .ipModulatedValid(ipModulatedValid), .ipI(ipI), .ipQ(ipQ),
    .ipSymbolStart(ipSymbolStart), .ipThreshold(ipThreshold),
    .opQAMBlock(blk[0]), .opQAMBlockValid(bv[0]), .opOverflow(ovf[0]),
    .opResyncCount(rsc[0])
`ifdef QAM_DEMOD_ACC_OUT_EN
    , .opAccI(accOutI[0]), .opAccQ(accOutQ[0])
`endif
  );

  qam_demodulator #(.SYMBOL_LEN(SYMBOL_LEN), .SHIFT(0), .ACC_W(44)) dut1 (
    .ipClk(ipClk), .ipReset(ipReset), .ipModulated(ipModulated),
    .ipModulatedValid(ipModulatedValid), .ipI(ipI), .ipQ(ipQ),
    .ipSymbolStart(ipSymbolStart), .ipThreshold(ipThreshold),
    .opQAMBlock(blk[1]), .opQAMBlockValid(bv[1]), .opOverflow(ovf[1]),
    .opResyncCount(rsc[1])
`ifdef QAM_DEMOD_ACC_OUT_EN
    , .opAccI(accOutI[1]), .opAccQ(accOutQ[1])
`endif
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int     due;
    longint sumI;
    longint sumQ;
  } pend_t;

  pend_t       pend[$];
  bit          active;
  int          nSamples;
  longint      sumI;
  longint      sumQ;
  logic [15:0] mResync;
  bit          mOvf [2];
  logic [3:0]  lastBlk [2];
  int          stepNo = 0;

  // Scale, clamp to signed 32 and slice one axis.
  function automatic void expAxis(input longint acc, input int sh, input logic [31:0] thr,
                                  output logic [1:0] bits, output bit sat,
                                  output logic [31:0] val);
    longint v;
    longint mag;
    v   = acc >>> sh;
    sat = 0;
    if (v > 64'sd2147483647) begin
      v = 64'sd2147483647; sat = 1;
    end else if (v < -64'sd2147483648) begin
      v = -64'sd2147483648; sat = 1;
    end
    val = v[31:0];
    mag = (v < 0) ? -v : v;
    if (mag > 64'sd2147483647) begin
      mag = 64'sd2147483647; sat = 1;
    end
    bits = {(v < 0), (mag > longint'({32'd0, thr}))};
  endfunction

  task automatic checkOutputs();
    bit          due;
    logic [1:0]  bI, bQ;
    bit          sI, sQ;
    logic [31:0] vI, vQ;
    due = (pend.size() != 0) && (pend[0].due == stepNo);
    for (int d = 0; d < 2; d++) begin
      if (due) begin
        expAxis(pend[0].sumI, (d == 0) ? 12 : 0, ipThreshold, bI, sI, vI);
        expAxis(pend[0].sumQ, (d == 0) ? 12 : 0, ipThreshold, bQ, sQ, vQ);
        if (sI || sQ) mOvf[d] = 1;
        check($sformatf("pulse%0d@%0d", d, stepNo), bv[d], 1);
        check($sformatf("block%0d@%0d", d, stepNo), blk[d], {bI, bQ});
`ifdef QAM_DEMOD_ACC_OUT_EN
        check($sformatf("accI%0d", d), accOutI[d], vI);
        check($sformatf("accQ%0d", d), accOutQ[d], vQ);
`endif
      end else begin
        check($sformatf("nopulse%0d@%0d", d, stepNo), bv[d], 0);
      end
      if (bv[d]) lastBlk[d] = blk[d];
      check($sformatf("ovf%0d@%0d", d, stepNo), ovf[d], mOvf[d]);
      check($sformatf("resync%0d@%0d", d, stepNo), rsc[d], mResync);
    end
    if (due) void'(pend.pop_front());
  endtask

  // One input cycle: drive, update the model, clock, check.
  task automatic step(input bit st, input bit vld, input logic [19:0] m,
                      input logic [17:0] i, input logic [17:0] q);
    ipSymbolStart    = st;
    ipModulatedValid = vld;
    ipModulated      = m;
    ipI              = i;
    ipQ              = q;
    if (st) begin
      if (!active) begin
        active = 1; nSamples = 0; sumI = 0; sumQ = 0;
      end else if (nSamples != 0) begin
        mResync = mResync + 16'd1; nSamples = 0; sumI = 0; sumQ = 0;
      end
    end
    if (active && vld) begin
      sumI += longint'($signed(m)) * longint'($signed(i));
      sumQ += longint'($signed(m)) * longint'($signed(q));
      nSamples++;
      if (nSamples == SYMBOL_LEN) begin
        pend.push_back('{due: stepNo + 2, sumI: sumI, sumQ: sumQ});
        nSamples = 0; sumI = 0; sumQ = 0;
      end
    end
    @(posedge ipClk);
    #1;
    checkOutputs();
    stepNo++;
  endtask

  task automatic idle(input int cnt);
    for (int k = 0; k < cnt; k++) step(0, 0, 20'd0, 18'd0, 18'd0);
  endtask

  task automatic sendSamples(input int cnt, input bit gap, input logic [19:0] m,
                             input logic [17:0] i, input logic [17:0] q);
    for (int k = 0; k < cnt; k++) begin
      step(0, 1, m, i, q);
      if (gap) step(0, 0, 20'd0, 18'd0, 18'd0);
    end
  endtask

  task automatic doReset();
    ipReset = 1; ipSymbolStart = 0; ipModulatedValid = 0;
    repeat (2) @(posedge ipClk);
    #1;
    ipReset = 0;
    active = 0; nSamples = 0; sumI = 0; sumQ = 0; mResync = 0;
    pend.delete();
    for (int d = 0; d < 2; d++) begin
      mOvf[d] = 0; lastBlk[d] = 0;
      check($sformatf("rst_block%0d", d), blk[d], 0);
      check($sformatf("rst_valid%0d", d), bv[d], 0);
      check($sformatf("rst_ovf%0d", d), ovf[d], 0);
      check($sformatf("rst_resync%0d", d), rsc[d], 0);
`ifdef QAM_DEMOD_ACC_OUT_EN
      check($sformatf("rst_accI%0d", d), accOutI[d], 0);
      check($sformatf("rst_accQ%0d", d), accOutQ[d], 0);
`endif
    end
  endtask

  // ---------------- stimulus ----------------
  logic [19:0] m1000;
  logic [17:0] p1000, n1000;

  initial begin
    m1000 = 20'd1000; p1000 = 18'd1000; n1000 = -18'sd1000;
    ipReset = 1; ipSymbolStart = 0; ipModulatedValid = 0;
    ipModulated = 0; ipI = 0; ipQ = 0; ipThreshold = 32'd10000;
    doReset();

    // Samples before any strobe are ignored.
    sendSamples(70, 0, m1000, p1000, n1000);

    // I acc 15625, Q acc -15625 against 10000.
    step(1, 0, 20'd0, 18'd0, 18'd0);
    sendSamples(SYMBOL_LEN, 0, m1000, p1000, n1000);
    idle(4);
    check("dir_thr10k", lastBlk[0], 4'b0111);

    // Same symbol against 20000.
    ipThreshold = 32'd20000;
    sendSamples(SYMBOL_LEN, 0, m1000, p1000, n1000);
    idle(4);
    check("dir_thr20k", lastBlk[0], 4'b0010);

    // Valid every other cycle.
    lastBlk[0] = 4'hF;
    sendSamples(SYMBOL_LEN, 1, m1000, p1000, n1000);
    idle(4);
    check("dir_gaps", lastBlk[0], 4'b0010);

    // Resync after 30 samples, then a full symbol.
    sendSamples(30, 0, m1000, p1000, n1000);
    step(1, 0, 20'd0, 18'd0, 18'd0);
    check("dir_resync_cnt", rsc[0], 16'd1);
    lastBlk[0] = 4'hF;
    sendSamples(SYMBOL_LEN, 0, m1000, p1000, n1000);
    idle(4);
    check("dir_after_resync", lastBlk[0], 4'b0010);

    // Strobe right after a completed symbol: no resync counted.
    step(1, 0, 20'd0, 18'd0, 18'd0);
    check("dir_aligned_strobe", rsc[0], 16'd1);

    // Full-scale products; dut1 (no shift) saturates both axes.
    ipThreshold = 32'd10000;
    sendSamples(SYMBOL_LEN, 0, 20'h7FFFF, 18'h1FFFF, 18'h20000);
    idle(4);
    check("dir_sat_block", lastBlk[1], 4'b0111);
    check("dir_sat_ovf", ovf[1], 1);
    check("dir_nosat_ovf", ovf[0], 0);
    idle(10);
    check("dir_ovf_sticky", ovf[1], 1);

    // Reset in the middle of a symbol; no output without a new strobe.
    sendSamples(40, 0, m1000, p1000, n1000);
    doReset();
    sendSamples(70, 0, m1000, p1000, n1000);
    idle(4);
    check("dir_post_reset_ovf", ovf[1], 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 799) == 0) doReset();
      if ($urandom_range(0, 15) == 0) ipThreshold = $urandom & 32'h07FF_FFFF;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           20'($urandom), 18'($urandom), 18'($urandom));
    end
    idle(5);
    check("drain", pend.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qam_demodulator.md
QAM_DEMODULATOR -- requirements
Module: qam_demodulator

Interface
REQ-001 SHALL have parameter SYMBOL_LEN, default 64: valid samples integrated per symbol, 2..65535.
REQ-002 SHALL have parameter SHIFT, default 12: arithmetic right shift applied to each dumped accumulator.
REQ-003 SHALL have parameter ACC_W, default 44: internal accumulator width, signed.
REQ-004 SHALL have port ipClk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port ipReset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port ipModulated  in  20  signed modulated sample.
REQ-007 SHALL have port ipModulatedValid  in  1  ipModulated qualifier.
REQ-008 SHALL have port ipI  in  18  signed NCO in-phase reference, sampled with ipModulated.
REQ-009 SHALL have port ipQ  in  18  signed NCO quadrature reference, sampled with ipModulated.
REQ-010 SHALL have port ipSymbolStart  in  1  one-cycle symbol-alignment strobe.
REQ-011 SHALL have port ipThreshold  in  32  unsigned outer-level magnitude threshold.
REQ-012 SHALL have port opQAMBlock  out  4  demodulated 16-QAM symbol.
REQ-013 SHALL have port opQAMBlockValid  out  1  one-cycle opQAMBlock qualifier.
REQ-014 SHALL have port opOverflow  out  1  sticky saturation flag.
REQ-015 SHALL have port opResyncCount  out  16  count of partial symbols discarded; wraps at 65535->0.

Function
REQ-016 SHALL use FSM states IDLE and INTEGRATE; reset enters IDLE.
REQ-017 In IDLE, samples SHALL be ignored; ipSymbolStart SHALL move to INTEGRATE and clear the sample counter and both accumulators.
REQ-018 Stage 1 SHALL register products ipModulated*ipI and ipModulated*ipQ (38-bit signed) with their valid bit.
REQ-019 Stage 2 SHALL add each valid product to its accumulator, sign-extended to ACC_W, and increment the sample counter.
REQ-020 On the SYMBOL_LEN-th valid product, stage 2 SHALL capture accumulator+product into dump registers and load zero, so the next sample is not lost.
REQ-021 Stage 3 SHALL shift each dump by SHIFT, saturate to signed 32, slice, and drive opQAMBlock with opQAMBlockValid high for one cycle.
REQ-022 Slicing: bit3 = I negative, bit2 = |I| > ipThreshold, bit1 = Q negative, bit0 = |Q| > ipThreshold.
REQ-023 The |x| of -2^31 SHALL saturate to 2^31-1.
REQ-024 Latency: opQAMBlockValid SHALL assert exactly 3 cycles after the ipModulatedValid cycle of the symbol's final sample.
REQ-025 Any saturation SHALL set opOverflow, which stays set until reset.
REQ-026 ipSymbolStart in INTEGRATE with counter nonzero SHALL discard the partial symbol, clear the counter and accumulators, and increment opResyncCount.
REQ-027 ipSymbolStart in INTEGRATE with counter zero SHALL have no effect.
REQ-028 ipSymbolStart coinciding with a final sample SHALL let the dump complete, then restart from zero without incrementing opResyncCount.
REQ-029 Samples in flight in stage 1 during a resync SHALL be dropped.
REQ-030 Gaps in ipModulatedValid SHALL stall counting only; no timeout applies.

Reset
REQ-031 ipReset SHALL set: opQAMBlock=0, opQAMBlockValid=0, opOverflow=0, opResyncCount=0, state IDLE, all pipeline registers and valids cleared.
REQ-032 Reset mid-symbol SHALL discard all partial data; the block then requires a new ipSymbolStart.

Configuration
REQ-033 With QAM_DEMOD_ACC_OUT_EN defined, the block SHALL add opAccI and opAccQ, out 32 signed, holding the last saturated dumped values, updated with opQAMBlockValid and reset to 0.
REQ-034 Without QAM_DEMOD_ACC_OUT_EN, those ports and registers SHALL be absent; all other behaviour is unchanged.

Structure
REQ-035 The Structures package SHALL hold the DEMOD_STATE enum (IDLE, INTEGRATE) and the QAM block width constant (4).
REQ-036 SHALL instantiate sub-module Integrator twice (I, Q); Integrator covers multiply, accumulate, dump and saturate. The top owns the FSM, counter, slicer and resync logic.

Verification
REQ-037 ipModulated=1000, ipI=1000, ipQ=-1000, 64 valid samples, ipThreshold=10000 -> opQAMBlock=4'b0111 (acc 15625), valid 3 cycles after sample 64.
REQ-038 Same stimulus, ipThreshold=20000 -> opQAMBlock=4'b0010.
REQ-039 Valid every other cycle -> identical result; one pulse 3 cycles after the 64th valid sample.
REQ-040 ipSymbolStart at sample 30 -> no output, opResyncCount=1, next pulse after 64 further samples.
REQ-041 ipModulated=524287, ipI=131071, SHIFT=0, 64 samples -> I dump 2147483647, bit2=1, opOverflow=1 held until reset.
REQ-042 ipReset at sample 40 -> all outputs 0, IDLE; samples without a new ipSymbolStart produce no output.
